// File: rtl/binary_clock_pkg.sv
// Shared constants and types for the BCD time-of-day counter.
// Digit maxima and field widths are fixed by the HH:MM display format.
package binary_clock_pkg;

   localparam int MIN_U_MAX     = 9;
   localparam int MIN_T_MAX     = 5;
   localparam int HR_U_MAX      = 9;
   localparam int HR_T_MAX      = 2;
   localparam int HR_WRAP_UNITS = 3;

   localparam int D3_W    = 2;
   localparam int D2_W    = 4;
   localparam int D1_W    = 4;
   localparam int D0_W    = 4;
   localparam int COUNT_W = D3_W + D2_W + D1_W + D0_W;

   typedef struct packed {
      logic [D3_W-1:0] d3;
      logic [D2_W-1:0] d2;
      logic [D1_W-1:0] d1;
      logic [D0_W-1:0] d0;
   } bcd_time_t;

endpackage

// File: rtl/binary_clock_bcd_digit.sv
// One wrapping BCD-style digit: counts 0..MAX on inc and flags the wrap
// combinationally so the next digit can advance on the same edge.
module bcd_digit #(
   parameter int W   = 4,
   parameter int MAX = 9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q,
   output logic         carry
);

   localparam logic [W-1:0] MAX_Q = W'(MAX);

   assign carry = inc && (q == MAX_Q);

   // NOTE: state is updated with <= only; reset is tested first so it wins over clr and inc.
   always_ff @(posedge clk) begin
      if (!reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc) begin
         q <= (q == MAX_Q) ? '0 : q + 1'b1;
      end
   end

endmodule

// File: rtl/binary_clock.sv
// 24-hour BCD HH:MM counter with a ce prescaler; advances one minute per
// CE_DIV ce-high cycles and presents the packed digits to the LED driver.
module binary_clock
   import binary_clock_pkg::*;
#(
   parameter int CE_DIV = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ce,
   output logic [COUNT_W-1:0] count
);

   localparam int                PRE_W    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
   localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CE_DIV - 1);
   localparam logic [D3_W-1:0]   HT_MAX   = D3_W'(HR_T_MAX);
   localparam logic [D2_W-1:0]   HU_MAX   = D2_W'(HR_U_MAX);
   localparam logic [D2_W-1:0]   HU_WRAP  = D2_W'(HR_WRAP_UNITS);

   logic [PRE_W-1:0] pre;
   logic             tick;
   logic [D3_W-1:0]  d3;
   logic [D2_W-1:0]  d2;
   logic [D1_W-1:0]  d1;
   logic [D0_W-1:0]  d0;
   logic             c0;
   logic             c1;
   logic             hr_wrap;
   bcd_time_t        now;

   assign tick = ce && (pre == PRE_LAST);

   // Partial prescale survives ce=0 gaps but is discarded by reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pre <= '0;
      end else if (ce) begin
         pre <= tick ? '0 : pre + 1'b1;
      end
   end

   bcd_digit #(.W(D0_W), .MAX(MIN_U_MAX)) u_d0 (
      .clk   (clk),
      .reset (reset),
      .inc   (tick),
      .clr   (1'b0),
      .q     (d0),
      .carry (c0)
   );

   bcd_digit #(.W(D1_W), .MAX(MIN_T_MAX)) u_d1 (
      .clk   (clk),
      .reset (reset),
      .inc   (c0),
      .clr   (1'b0),
      .q     (d1),
      .carry (c1)
   );

   // Hours are not two independent digits: 23 must wrap to 00, not 24.
   assign hr_wrap = (d3 == HT_MAX) && (d2 == HU_WRAP);

   always_ff @(posedge clk) begin
      if (!reset) begin
         d3 <= '0;
         d2 <= '0;
      end else if (c1) begin
         if (hr_wrap) begin
            d3 <= '0;
            d2 <= '0;
         end else if (d2 == HU_MAX) begin
            d3 <= d3 + 1'b1;
            d2 <= '0;
         end else begin
            d2 <= d2 + 1'b1;
         end
      end
   end

   assign now   = '{d3: d3, d2: d2, d1: d1, d0: d0};
   assign count = now;

endmodule

// File: tb/tb_binary_clock.sv
// Self-checking bench for binary_clock: a minutes-based reference model feeds
// a scoreboard every cycle; table rows and hand sequences add end-point checks.
module tb_binary_clock;
   import binary_clock_pkg::*;

   logic               clk;
   logic               reset1, ce1, reset4, ce4;
   logic [COUNT_W-1:0] count1, count4;

   int checks = 0;
   int errors = 0;

   // Reference state: minutes since midnight plus prescaler phase.
   int m1 = 0, p1 = 0, m4 = 0, p4 = 0;
   logic [COUNT_W-1:0] sb1[$];
   logic [COUNT_W-1:0] sb4[$];

   typedef struct {
      string              name;
      logic               ce;
      int                 cycles;
      logic [COUNT_W-1:0] exp;
   } vec_t;

   vec_t vecs[$];

   binary_clock #(.CE_DIV(1)) dut (
      .clk   (clk),
      .reset (reset1),
      .ce    (ce1),
      .count (count1)
   );

   binary_clock #(.CE_DIV(4)) dut4 (
      .clk   (clk),
      .reset (reset4),
      .ce    (ce4),
      .count (count4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [COUNT_W-1:0] to_bcd(input int m);
      int h, mm;
      bcd_time_t t;
      h    = m / 60;
      mm   = m % 60;
      t.d3 = D3_W'(h / 10);
      t.d2 = D2_W'(h % 10);
      t.d1 = D1_W'(mm / 10);
      t.d0 = D0_W'(mm % 10);
      return t;
   endfunction

   task automatic check(input string name, input logic [COUNT_W-1:0] act,
                        input logic [COUNT_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model(input logic r, input logic c, input int div,
                        inout int m, inout int p);
      if (!r) begin
         m = 0;
         p = 0;
      end else if (c) begin
         if (p == div - 1) begin
            p = 0;
            m = (m + 1) % 1440;
         end else begin
            p++;
         end
      end
   endtask

   // One clock: drive both DUTs, predict, push, then compare after the edge.
   task automatic step(input logic r1, input logic c1, input logic r4, input logic c4);
      reset1 = r1;
      ce1    = c1;
      reset4 = r4;
      ce4    = c4;
      model(r1, c1, 1, m1, p1);
      model(r4, c4, 4, m4, p4);
      sb1.push_back(to_bcd(m1));
      sb4.push_back(to_bcd(m4));
      @(posedge clk);
      #1;
      check("sb_div1", count1, sb1.pop_front());
      check("sb_div4", count4, sb4.pop_front());
   endtask

   initial begin
      reset1 = 1'b1;
      ce1    = 1'b0;
      reset4 = 1'b1;
      ce4    = 1'b0;

      vecs.push_back('{"run10",      1'b1,   10, 14'h0010});
      vecs.push_back('{"to_0100",    1'b1,   50, 14'h0100});
      vecs.push_back('{"to_2300",    1'b1, 1320, 14'h2300});
      vecs.push_back('{"to_2359",    1'b1,   59, 14'h2359});
      vecs.push_back('{"wrap_0000",  1'b1,    1, 14'h0000});
      vecs.push_back('{"day2_2300",  1'b1, 1380, 14'h2300});
      vecs.push_back('{"day2_0000",  1'b1,   60, 14'h0000});
      vecs.push_back('{"to_1234",    1'b1,  754, 14'h1234});
      vecs.push_back('{"hold_1234",  1'b0,   50, 14'h1234});
      vecs.push_back('{"to_0547",    1'b1, 1033, 14'h0547});

      // Reset both DUTs for one cycle with ce high.
      step(1'b0, 1'b1, 1'b0, 1'b1);
      check("reset_count", count1, 14'h0000);
      check("reset_digits", {dut.d3, dut.d2, dut.d1, dut.d0}, 14'h0000);
      check("reset_div4", count4, 14'h0000);

      foreach (vecs[i]) begin
         for (int k = 0; k < vecs[i].cycles; k++) step(1'b1, vecs[i].ce, 1'b1, 1'b0);
         check(vecs[i].name, count1, vecs[i].exp);
      end
      check("digits_0547", {dut.d3, dut.d2, dut.d1, dut.d0}, 14'h0547);

      // Reset wins over a simultaneous tick, then counting resumes one clock later.
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check("reset_beats_tick", count1, 14'h0000);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("first_inc", count1, 14'h0001);

      // CE_DIV=4 with ce toggled every other clock: 8 ce-high cycles, 2 minutes.
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0, 1'b1, (i % 2) == 0);
         if (i == 3) check("pre_kept", 14'(dut4.pre), 14'd2);
      end
      check("div4_two_min", count4, 14'h0002);

      // Reset mid-prescale discards the partial count.
      step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check("div4_reset", count4, 14'h0000);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
      check("div4_partial", count4, 14'h0000);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      check("div4_after_reset", count4, 14'h0001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
